pwl_frame_seq: RTL
==================

Name: pwl_frame_seq

Overview:
- Frame sequencer/scheduler in front of the 4-lane up-PWL datapath (LANES x SAMPLES array of CODE_W-bit codes -> signed 8-bit outputs).
- Collects a beat stream of per-sample codes into ping-pong frame buffers.
- Launches complete frames into the datapath, drives its sync reset, and tracks pipeline latency so each result frame gets a valid pulse and tag.

Parameters:
- LANES, 4, lanes driven in parallel (one up-PWL instance each)
- SAMPLES, 8, samples per lane per frame (beats per frame)
- CODE_W, 6, bits per input code
- PIPE_LAT, 2, cycles from launch to datapath output registers valid (>=1)
- TAG_W, 4, frame tag width
- PAD_CODE, 6'h20, code used to fill samples of a short frame

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat ready
- s_code  in  LANES*CODE_W  one sample index across all lanes; lane l at [l*CODE_W +: CODE_W]
- s_last  in  1  final beat of frame
- run  in  1  launch enable; 0 holds completed frames
- flush  in  1  single-cycle abort
- pwl_x  out  LANES*SAMPLES*CODE_W  datapath code inputs; lane l, sample k at [(l*SAMPLES+k)*CODE_W +: CODE_W]
- dp_rstb  out  1  datapath sync reset, active-low
- launch  out  1  pulse: pwl_x carries a new frame this cycle
- out_valid  out  1  pulse: datapath outputs hold the frame with out_tag
- out_tag  out  TAG_W  tag of the frame at datapath output
- err_short  out  1  pulse: frame closed early by s_last
- err_long  out  1  pulse: SAMPLES beats without s_last

Behaviour:
- Reset (rst=1 at clk edge):
  - s_ready=0 during reset, 1 on the first cycle after.
  - pwl_x=0, launch=0, out_valid=0, out_tag=0, err_*=0, dp_rstb=0.
  - Both buffers empty; fill index=0; next tag=0.
- dp_rstb: 0 during rst and for exactly 1 cycle after a flush edge; 1 otherwise.
- Beat accepted on s_valid&s_ready. It writes s_code into sample slot idx of the fill buffer; idx increments.
- Frame close conditions:
  - s_last on beat idx<SAMPLES-1: slots idx+1..SAMPLES-1 are written PAD_CODE; err_short pulses the next cycle.
  - idx=SAMPLES-1 with s_last=1: normal close.
  - idx=SAMPLES-1 with s_last=0: frame closed anyway; err_long pulses; the next beat starts a new frame.
- On close: fill buffer marked full, fill side toggles to the other buffer, idx=0.
- s_ready = fill buffer not full. When both buffers are full, s_ready=0 until one launches.
- Launch FSM, states L_IDLE and L_ISSUE:
  - L_IDLE -> L_ISSUE when run=1 and the oldest full buffer exists.
  - In L_ISSUE, pwl_x is registered from that buffer and launch=1 for one cycle. The buffer is freed and the FSM returns to L_IDLE.
  - Max 1 launch/cycle, so back-to-back launches are possible (every other cycle at minimum via FSM; consecutive full buffers issue in cycles N and N+2).
  - pwl_x holds its last frame between launches.
- Latency: last beat accepted at edge T -> buffer full at T+1 -> launch asserted at T+2 (run=1, FSM idle).
- Tracking: shift register of depth PIPE_LAT carries {valid, tag}. out_valid/out_tag appear exactly PIPE_LAT cycles after launch. Tag increments per launch, wrapping mod 2^TAG_W.
- No backpressure from the output side; the consumer must accept out_valid pulses.
- Simultaneous close and launch from the same cycle: a buffer freed this cycle is not refillable until the next cycle.
- Frame ordering is strictly FIFO across the two buffers.
- flush:
  - Discards the partial fill and both full buffers; clears the tracking pipe (in-flight out_valid suppressed).
  - Pulses dp_rstb low; FSM goes to L_IDLE; pwl_x is held.
  - Next tag is NOT reset.
  - A beat presented with flush is dropped (s_ready=0 that cycle).
- rst takes priority over flush. Reset mid-frame discards everything and returns to reset values.

Optional Feature:
- Macro PWL_FRAME_SEQ_CNT_EN.
- When defined:
  - Adds outputs frames_launched (16 bits) and err_count (8 bits).
  - frames_launched increments per launch; err_count increments per err_short/err_long pulse, saturating at 8'hFF.
  - Both counters clear on rst only, not on flush.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, run=1, 8 beats with lane l sample k code = l*8+k, s_last on beat 7 -> launch 2 cycles after last beat; pwl_x slot (l,k) = l*8+k; out_valid with out_tag=0 exactly 2 cycles after launch.
- 3 back-to-back frames, run=1 -> s_ready stays 1; launches 8 cycles apart; out_tag 0,1,2; no err pulses.
- run=0, stream 16 beats (2 frames) -> s_ready=0 after beat 16; 17th beat stalled. run=1 -> launches at cycles N and N+2 in FIFO order; s_ready returns.
- s_last on beat 4 (codes 1..5 on all lanes) -> samples 5..7 = 6'h20; err_short single pulse. Beat 7 without s_last on the next frame -> err_long pulse; the frame still launches.
- flush after 3 beats of a frame, with one frame in flight (launched 1 cycle earlier) -> dp_rstb low 1 cycle; no out_valid for the in-flight frame; the following full frame launches with the next tag value.
- 17 frames -> out_tag wraps 15 -> 0. With PWL_FRAME_SEQ_CNT_EN defined, frames_launched=17 after the run.

Source files
------------

// File: rtl/pwl_frame_seq_if.sv
// Beat-stream handshake between the code producer and pwl_frame_seq.
interface pwl_frame_seq_if #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned CODE_W = 6
);
    logic                      s_valid;
    logic                      s_ready;
    logic [LANES*CODE_W-1:0]   s_code;
    logic                      s_last;

    modport master (output s_valid, output s_code, output s_last, input  s_ready);
    modport slave  (input  s_valid, input  s_code, input  s_last, output s_ready);
endinterface

// File: rtl/pwl_frame_seq.sv
// Frame sequencer: collects code beats into ping-pong buffers, launches frames into the
// up-PWL datapath and tags results. Define PWL_FRAME_SEQ_CNT_EN for status counters.
module pwl_frame_seq #(
    parameter int unsigned       LANES    = 4,
    parameter int unsigned       SAMPLES  = 8,
    parameter int unsigned       CODE_W   = 6,
    parameter int unsigned       PIPE_LAT = 2,
    parameter int unsigned       TAG_W    = 4,
    parameter logic [CODE_W-1:0] PAD_CODE = 6'h20
) (
    input  logic                              clk,
    input  logic                              rst,
    pwl_frame_seq_if.slave                    s,
    input  logic                              run,
    input  logic                              flush,
    output logic [LANES*SAMPLES*CODE_W-1:0]   pwl_x,
    output logic                              dp_rstb,
    output logic                              launch,
    output logic                              out_valid,
    output logic [TAG_W-1:0]                  out_tag,
    output logic                              err_short,
    output logic                              err_long
`ifdef PWL_FRAME_SEQ_CNT_EN
    ,
    output logic [15:0]                       frames_launched,
    output logic [7:0]                        err_count
`endif
);
    localparam int unsigned BEAT_W = LANES * CODE_W;
    localparam int unsigned IDX_W  = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

    typedef enum logic {L_IDLE, L_ISSUE} lstate_t;

    lstate_t                       state_q, state_d;
    logic [BEAT_W-1:0]             buf_q [2][SAMPLES];
    logic [1:0]                    full_q;
    logic                          fill_sel;
    logic                          rd_sel;
    logic [IDX_W-1:0]              idx_q;
    logic [TAG_W-1:0]              next_tag;
    logic [TAG_W-1:0]              launch_tag;
    logic [PIPE_LAT-1:0]           pipe_v;
    logic [TAG_W-1:0]              pipe_tag [PIPE_LAT];
    logic [LANES*SAMPLES*CODE_W-1:0] frame_packed;
    logic                          accept;
    logic                          at_end;
    logic                          close;
    logic                          short_d;
    logic                          long_d;
    logic                          issue;

    assign s.s_ready = !rst && !flush && !full_q[fill_sel];
    assign accept    = s.s_valid && s.s_ready;
    assign at_end    = (idx_q == IDX_W'(SAMPLES - 1));
    assign close     = accept && (s.s_last || at_end);
    assign short_d   = close && s.s_last && !at_end;
    assign long_d    = close && !s.s_last;

    // Launch FSM
    always_ff @(posedge clk) begin
        if (rst) state_q <= L_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = L_IDLE;
        end else begin
            case (state_q)
                L_IDLE:  if (run && full_q[rd_sel]) state_d = L_ISSUE;
                L_ISSUE: state_d = L_IDLE;
                default: state_d = L_IDLE;
            endcase
        end
    end

    always_comb begin
        issue = (state_q == L_ISSUE) && !flush;
    end

    // Beat storage; a short frame pads every slot after the closing beat.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned k = 0; k < SAMPLES; k++) begin
                if (IDX_W'(k) == idx_q)
                    buf_q[fill_sel][k] <= s.s_code;
                else if (s.s_last && (IDX_W'(k) > idx_q))
                    buf_q[fill_sel][k] <= {LANES{PAD_CODE}};
            end
        end
    end

    // Reorder sample-major buffer storage into the lane-major datapath layout.
    always_comb begin
        frame_packed = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            for (int unsigned k = 0; k < SAMPLES; k++) begin
                frame_packed[(l*SAMPLES+k)*CODE_W +: CODE_W] = buf_q[rd_sel][k][l*CODE_W +: CODE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= '0;
            fill_sel   <= 1'b0;
            rd_sel     <= 1'b0;
            idx_q      <= '0;
            pwl_x      <= '0;
            launch     <= 1'b0;
            next_tag   <= '0;
            launch_tag <= '0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            dp_rstb    <= 1'b0;
        end else begin
            dp_rstb   <= !flush;
            launch    <= issue;
            err_short <= short_d;
            err_long  <= long_d;
            if (flush) begin
                full_q   <= '0;
                fill_sel <= 1'b0;
                rd_sel   <= 1'b0;
                idx_q    <= '0;
            end else begin
                if (accept) idx_q <= close ? '0 : idx_q + IDX_W'(1);
                if (close) begin
                    full_q[fill_sel] <= 1'b1;
                    fill_sel         <= ~fill_sel;
                end
                if (issue) begin
                    full_q[rd_sel] <= 1'b0;
                    rd_sel         <= ~rd_sel;
                    pwl_x          <= frame_packed;
                    launch_tag     <= next_tag;
                    next_tag       <= next_tag + TAG_W'(1);
                end
            end
        end
    end

    // Result tracking: stage 0 captures the launch register, so depth PIPE_LAT lines up.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pipe_v <= '0;
            for (int unsigned i = 0; i < PIPE_LAT; i++) pipe_tag[i] <= '0;
        end else begin
            pipe_v[0]   <= launch;
            pipe_tag[0] <= launch_tag;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    assign out_valid = pipe_v[PIPE_LAT-1];
    assign out_tag   = pipe_tag[PIPE_LAT-1];

`ifdef PWL_FRAME_SEQ_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_launched <= '0;
            err_count       <= '0;
        end else begin
            if (issue) frames_launched <= frames_launched + 16'd1;
            if ((short_d || long_d) && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end
`endif
endmodule
